// File: rtl/measure_sequencer.sv
// measure_sequencer
// Master timing generator for one Raman acquisition. It owns the point, shot
// and save-block counters that every downstream block decodes. It also
// derives the laser trigger and the ADC sample window from those counters,
// and it hands each finished block to the memory dumper through a req/ack
// handshake.
//
// Counters only wrap at their terminal values, so no overflow path exists.
// All decoded outputs are pure functions of the registered state and the
// registered counters. They therefore change only after a clock edge or an
// asynchronous reset, never in response to an input within the same cycle.

module measure_sequencer #(
  parameter int POINTS   = 1000,  // sample points per shot, 1..1500
  parameter int TAIL     = 60,    // guard cycles after last point, >= 51
  parameter int MEASURES = 1000,  // shots per block, 1..131072
  parameter int SAVES    = 2,     // blocks per acquisition, 1..16
  parameter int PULSE_W  = 4      // laser trigger width, 1..POINTS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        save_ack,
  output logic [10:0] cnt_point,
  output logic [16:0] cnt_measure,
  output logic [3:0]  cnt_save,
  output logic        laser_trig,
  output logic        sample_en,
  output logic        save_req,
  output logic        busy,
  output logic        done
);

  // Shot period and terminal counter values, sized to the counter widths so
  // every comparison below is width-matched.
  localparam int          PERIOD    = POINTS + TAIL;
  localparam logic [10:0] PT_LAST   = 11'(PERIOD - 1);
  localparam logic [10:0] PT_POINTS = 11'(POINTS);
  localparam logic [10:0] PT_PULSE  = 11'(PULSE_W);
  localparam logic [16:0] MS_LAST   = 17'(MEASURES - 1);
  localparam logic [3:0]  SV_LAST   = 4'(SAVES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAVE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q,   state_d;
  logic [10:0] point_q,   point_d;
  logic [16:0] measure_q, measure_d;
  logic [3:0]  save_q,    save_d;

  // Terminal-count flags used by the RUN and SAVE transitions.
  logic shot_end_s;
  logic block_end_s;
  logic last_save_s;

  assign shot_end_s  = (point_q == PT_LAST);
  assign block_end_s = shot_end_s && (measure_q == MS_LAST);
  assign last_save_s = (save_q == SV_LAST);

  // State and counter registers; async reset returns everything to IDLE/0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      point_q   <= 11'd0;
      measure_q <= 17'd0;
      save_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      point_q   <= point_d;
      measure_q <= measure_d;
      save_q    <= save_d;
    end
  end

  // Next-state and counter update. stop overrides everything. Otherwise each
  // state decides how the counters advance, hold or clear.
  always_comb begin
    state_d   = state_q;
    point_d   = point_q;
    measure_d = measure_q;
    save_d    = save_q;

    if (stop) begin
      // Abort: drop any pending save request and clear every counter.
      state_d   = ST_IDLE;
      point_d   = 11'd0;
      measure_d = 17'd0;
      save_d    = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Counters are pinned at zero while idle.
          point_d   = 11'd0;
          measure_d = 17'd0;
          save_d    = 4'd0;
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_RUN: begin
          if (block_end_s) begin
            // Last point of the last shot: the block is complete.
            state_d   = ST_SAVE;
            point_d   = 11'd0;
            measure_d = 17'd0;
          end else if (shot_end_s) begin
            point_d   = 11'd0;
            measure_d = measure_q + 17'd1;
          end else begin
            point_d   = point_q + 11'd1;
          end
        end

        ST_SAVE: begin
          // The shot counters stay at zero, so the switch-controller pair
          // cannot reappear while the dumper drains the block.
          point_d   = 11'd0;
          measure_d = 17'd0;
          if (save_ack) begin
            if (last_save_s) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
              save_d  = save_q + 4'd1;
            end
          end else begin
            state_d = ST_SAVE;
          end
        end

        ST_DONE: begin
          // Counters hold their final values until a new acquisition starts.
          if (start) begin
            state_d   = ST_RUN;
            point_d   = 11'd0;
            measure_d = 17'd0;
            save_d    = 4'd0;
          end else begin
            state_d = ST_DONE;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          point_d   = 11'd0;
          measure_d = 17'd0;
          save_d    = 4'd0;
        end
      endcase
    end
  end

  // Counter outputs come straight from the registers.
  assign cnt_point   = point_q;
  assign cnt_measure = measure_q;
  assign cnt_save    = save_q;

  // Decoded outputs depend only on registered state and counters.
  assign laser_trig = (state_q == ST_RUN) && (point_q < PT_PULSE);
  assign sample_en  = (state_q == ST_RUN) && (point_q < PT_POINTS);
  assign save_req   = (state_q == ST_SAVE);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_SAVE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_measure_sequencer.sv
// Testbench for measure_sequencer. Two instances share the clock and reset.
// Instance A uses the nominal test parameters (PERIOD = 64, 3 shots, 2 blocks).
// Instance B uses the edge parameters (MEASURES = 1, SAVES = 1, TAIL = 51).
// Each instance has a reference model that tracks elapsed clocks in the
// current block, and the counters are derived from that with / and %.

module tb_measure_sequencer;

  localparam int A_PTS = 4, A_TAIL = 60, A_MEAS = 3, A_SAV = 2, A_PW = 2;
  localparam int B_PTS = 4, B_TAIL = 51, B_MEAS = 1, B_SAV = 1, B_PW = 2;
  localparam int A_PER = A_PTS + A_TAIL;
  localparam int B_PER = B_PTS + B_TAIL;

  localparam int M_IDLE = 0, M_RUN = 1, M_SAVE = 2, M_DONE = 3;

  typedef struct packed {
    int mode;
    int t;     // clocks elapsed in the current block while running
    int blk;   // block index within the acquisition
  } mdl_t;

  logic clk, rst_n;
  logic a_start, a_stop, a_ack, b_start, b_stop, b_ack;
  logic [10:0] a_pt, b_pt;
  logic [16:0] a_ms, b_ms;
  logic [3:0]  a_sv, b_sv;
  logic a_lt, a_se, a_sr, a_bz, a_dn;
  logic b_lt, b_se, b_sr, b_bz, b_dn;

  int   n_cmp, n_err;
  mdl_t ma, mb;
  int   a_run, a_pair, b_run, b_pair;
  logic a_prev_sr, b_prev_sr;

  measure_sequencer #(.POINTS(A_PTS), .TAIL(A_TAIL), .MEASURES(A_MEAS),
                      .SAVES(A_SAV), .PULSE_W(A_PW)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .save_ack(a_ack),
    .cnt_point(a_pt), .cnt_measure(a_ms), .cnt_save(a_sv),
    .laser_trig(a_lt), .sample_en(a_se), .save_req(a_sr), .busy(a_bz), .done(a_dn));

  measure_sequencer #(.POINTS(B_PTS), .TAIL(B_TAIL), .MEASURES(B_MEAS),
                      .SAVES(B_SAV), .PULSE_W(B_PW)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .save_ack(b_ack),
    .cnt_point(b_pt), .cnt_measure(b_ms), .cnt_save(b_sv),
    .laser_trig(b_lt), .sample_en(b_se), .save_req(b_sr), .busy(b_bz), .done(b_dn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference behaviour of one acquisition, one clock at a time.
  function automatic mdl_t mdl_step(mdl_t m, int per, int meas, int sav,
                                    logic st, logic sp, logic ak);
    mdl_t n = m;
    if (sp) begin
      n = '0;
    end else begin
      case (m.mode)
        M_IDLE: if (st) begin n.mode = M_RUN; n.t = 0; n.blk = 0; end
        M_RUN: begin
          n.t = m.t + 1;
          if (n.t == meas * per) begin n.mode = M_SAVE; n.t = 0; end
        end
        M_SAVE: if (ak) begin
          n.t = 0;
          if (m.blk == sav - 1) n.mode = M_DONE;
          else begin n.mode = M_RUN; n.blk = m.blk + 1; end
        end
        M_DONE: if (st) begin n.mode = M_RUN; n.t = 0; n.blk = 0; end
        default: n = '0;
      endcase
    end
    return n;
  endfunction

  task automatic cmp_a();
    bit run = (ma.mode == M_RUN);
    int ph  = ma.t % A_PER;
    chk("A.cnt_point",   32'(a_pt), run ? ph : 0);
    chk("A.cnt_measure", 32'(a_ms), run ? ma.t / A_PER : 0);
    chk("A.cnt_save",    32'(a_sv), ma.blk);
    chk("A.laser_trig",  32'(a_lt), 32'(run && ph < A_PW));
    chk("A.sample_en",   32'(a_se), 32'(run && ph < A_PTS));
    chk("A.save_req",    32'(a_sr), 32'(ma.mode == M_SAVE));
    chk("A.busy",        32'(a_bz), 32'(run || ma.mode == M_SAVE));
    chk("A.done",        32'(a_dn), 32'(ma.mode == M_DONE));
  endtask

  task automatic cmp_b();
    bit run = (mb.mode == M_RUN);
    int ph  = mb.t % B_PER;
    chk("B.cnt_point",   32'(b_pt), run ? ph : 0);
    chk("B.cnt_measure", 32'(b_ms), run ? mb.t / B_PER : 0);
    chk("B.cnt_save",    32'(b_sv), mb.blk);
    chk("B.laser_trig",  32'(b_lt), 32'(run && ph < B_PW));
    chk("B.sample_en",   32'(b_se), 32'(run && ph < B_PTS));
    chk("B.save_req",    32'(b_sr), 32'(mb.mode == M_SAVE));
    chk("B.busy",        32'(b_bz), 32'(run || mb.mode == M_SAVE));
    chk("B.done",        32'(b_dn), 32'(mb.mode == M_DONE));
  endtask

  // Per-block bookkeeping: RUN length and switch-pair occurrences, checked
  // when each save request rises.
  task automatic block_stats();
    if (a_bz && !a_sr) a_run++;
    if (a_ms == 17'd2 && a_pt == 11'd54) a_pair++;
    if (a_sr && !a_prev_sr) begin
      chk("A.block_run_len", a_run, A_MEAS * A_PER);
      chk("A.switch_pair", a_pair, 1);
      a_run = 0; a_pair = 0;
    end
    if (!a_bz) begin a_run = 0; a_pair = 0; end
    a_prev_sr = a_sr;

    if (b_bz && !b_sr) b_run++;
    if (b_ms == 17'd0 && b_pt == 11'd54) b_pair++;
    if (b_sr && !b_prev_sr) begin
      chk("B.block_run_len", b_run, 55);
      chk("B.switch_pair", b_pair, 1);
      b_run = 0; b_pair = 0;
    end
    if (!b_bz) begin b_run = 0; b_pair = 0; end
    b_prev_sr = b_sr;
  endtask

  // One clock: models advance on the edge, outputs compared on the negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      ma = '0; mb = '0;
    end else begin
      ma = mdl_step(ma, A_PER, A_MEAS, A_SAV, a_start, a_stop, a_ack);
      mb = mdl_step(mb, B_PER, B_MEAS, B_SAV, b_start, b_stop, b_ack);
    end
    @(negedge clk);
    cmp_a();
    cmp_b();
    block_stats();
  endtask

  task automatic wait_a_req(input int bound);
    int k = 0;
    while (!a_sr && k < bound) begin tick(); k++; end
    chk("A.req_timeout", 32'(a_sr), 1);
  endtask

  task automatic wait_b_req(input int bound);
    int k = 0;
    while (!b_sr && k < bound) begin tick(); k++; end
    chk("B.req_timeout", 32'(b_sr), 1);
  endtask

  initial begin
    int k;
    n_cmp = 0; n_err = 0;
    ma = '0; mb = '0;
    a_run = 0; a_pair = 0; b_run = 0; b_pair = 0;
    a_prev_sr = 1'b0; b_prev_sr = 1'b0;
    rst_n = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_ack = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_ack = 1'b0;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic start
    a_start = 1'b1; tick(); a_start = 1'b0;
    wait_a_req(300);

    // Full acquisition, ack 5 clocks after each request
    repeat (4) tick();
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    chk("A.after_ack1_save", 32'(a_sv), 1);
    chk("A.after_ack1_busy", 32'(a_bz), 1);
    wait_a_req(300);
    repeat (4) tick();
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    chk("A.final_done", 32'(a_dn), 1);
    chk("A.final_busy", 32'(a_bz), 0);
    chk("A.final_save", 32'(a_sv), 1);
    repeat (3) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("A.restart_save", 32'(a_sv), 0);
    chk("A.restart_laser", 32'(a_lt), 1);

    // Stalled save with random ignored start pulses
    wait_a_req(300);
    for (int i = 0; i < 1000; i++) begin
      a_start = 1'($urandom_range(0, 1));
      tick();
    end
    a_start = 1'b0;
    chk("A.stall_req", 32'(a_sr), 1);
    chk("A.stall_laser", 32'(a_lt), 0);
    chk("A.stall_sample", 32'(a_se), 0);
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    chk("A.resume_pt", 32'(a_pt), 0);
    chk("A.resume_laser", 32'(a_lt), 1);
    chk("A.resume_req", 32'(a_sr), 0);

    // Abort at cnt_measure=1, cnt_point=30 with start also high
    k = 0;
    while (!(a_ms == 17'd1 && a_pt == 11'd30) && k < 400) begin tick(); k++; end
    chk("A.abort_reach", 32'(a_ms == 17'd1 && a_pt == 11'd30), 1);
    a_stop = 1'b1; a_start = 1'b1; tick(); a_stop = 1'b0; a_start = 1'b0;
    chk("A.abort_busy", 32'(a_bz), 0);
    chk("A.abort_pt", 32'(a_pt), 0);
    chk("A.abort_save", 32'(a_sv), 0);
    a_ack = 1'b1; b_ack = 1'b1; tick(); a_ack = 1'b0; b_ack = 1'b0;
    tick();
    chk("A.stray_ack_busy", 32'(a_bz), 0);

    // Asynchronous reset in the middle of SAVE
    a_start = 1'b1; tick(); a_start = 1'b0;
    wait_a_req(300);
    repeat (2) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("A.arst_pt", 32'(a_pt), 0);
    chk("A.arst_ms", 32'(a_ms), 0);
    chk("A.arst_sv", 32'(a_sv), 0);
    chk("A.arst_outs", 32'({a_lt, a_se, a_sr, a_bz, a_dn}), 0);
    ma = '0; mb = '0;
    tick();
    rst_n = 1'b1;
    tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    wait_a_req(300);

    // Edge parameters
    b_start = 1'b1; tick(); b_start = 1'b0;
    wait_b_req(100);
    repeat ($urandom_range(0, 3)) tick();
    b_ack = 1'b1; tick(); b_ack = 1'b0;
    chk("B.done", 32'(b_dn), 1);
    chk("B.done_busy", 32'(b_bz), 0);

    // Random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      a_start = 1'($urandom_range(0, 29) == 0);
      a_stop  = 1'($urandom_range(0, 1499) == 0);
      a_ack   = 1'($urandom_range(0, 7) == 0);
      b_start = 1'($urandom_range(0, 29) == 0);
      b_stop  = 1'($urandom_range(0, 999) == 0);
      b_ack   = 1'($urandom_range(0, 7) == 0);
      tick();
    end
    a_start = 1'b0; a_stop = 1'b0; a_ack = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
